// File: rtl/rnn_spike_decoder_pkg.sv
// ============================================================================
// Module   : rnn_pkg
// Purpose  : Shared FSM encoding, saturation limit and defaults for the spike decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rnn_pkg;

    localparam int unsigned  c_win_log2_default = 8;
    localparam logic [7:0]   c_sat_max          = 8'd255;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Adds a single bit to an 8-bit value, sticking at the ceiling instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic b);
        return (a == c_sat_max) ? c_sat_max : a + {7'd0, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rnn_spike_decoder_if.sv
// ============================================================================
// Module   : rnn_spike_decoder_if
// Purpose  : Spike input, control and rate/ISI result bundle of the decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rnn_spike_decoder_if;
    logic       ena;
    logic       spike_in;
    logic       clear;
    logic       out_ready;
    logic [7:0] rate_out;
    logic       out_valid;
    logic [7:0] isi_out;
    logic       overrun;

    modport master (
        output ena, spike_in, clear, out_ready,
        input  rate_out, out_valid, isi_out, overrun
    );

    modport slave (
        input  ena, spike_in, clear, out_ready,
        output rate_out, out_valid, isi_out, overrun
    );
endinterface

`default_nettype wire

// File: rtl/rnn_sat_counter.sv
// ============================================================================
// Module   : rnn_sat_counter
// Purpose  : 8-bit up-counter with enable and synchronous clear, saturating at 255.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rnn_sat_counter
    import rnn_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clear,
    input  wire logic       i_en,
    output logic [7:0]      o_count
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= sat_add(r_count, 1'b1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rnn_spike_decoder.sv
// ============================================================================
// Module   : rnn_spike_decoder
// Purpose  : Rate decoder (spikes per 2^WIN_LOG2 enabled cycles) plus inter-spike interval.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rnn_spike_decoder
    import rnn_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = c_win_log2_default
) (
    input  wire logic               clk,
    input  wire logic               rst,
    rnn_spike_decoder_if.slave      bus
);

    localparam logic [WIN_LOG2-1:0] c_win_last = '1;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_cnt_en;
    logic                w_spike;
    logic                w_win_end;
    logic [WIN_LOG2-1:0] r_win_ctr;
    logic [7:0]          w_spk_cnt;
    logic [7:0]          w_isi_ctr;
    logic [7:0]          r_rate_out;
    logic [7:0]          r_isi_out;
    logic                r_out_valid;
    logic                r_overrun;
    logic                r_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.ena) w_state_next = ST_COUNT;
                ST_COUNT: w_state_next = ST_COUNT;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // The IDLE->COUNT cycle is itself window cycle 0, so both states count on ena.
    always_comb begin
        w_cnt_en = 1'b0;
        case (r_state)
            ST_IDLE:  w_cnt_en = bus.ena;
            ST_COUNT: w_cnt_en = bus.ena;
            default:  w_cnt_en = 1'b0;
        endcase
    end

    assign w_spike   = w_cnt_en & bus.spike_in;
    assign w_win_end = w_cnt_en & (r_win_ctr == c_win_last);

    rnn_sat_counter u_spk_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.clear | w_win_end),
        .i_en    (w_spike),
        .o_count (w_spk_cnt)
    );

    rnn_sat_counter u_isi_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.clear | w_spike),
        .i_en    (w_cnt_en & ~bus.spike_in),
        .o_count (w_isi_ctr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_ctr   <= '0;
            r_rate_out  <= 8'd0;
            r_isi_out   <= 8'd0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_seen      <= 1'b0;
        end else if (bus.clear) begin
            r_win_ctr   <= '0;
            r_rate_out  <= 8'd0;
            r_isi_out   <= 8'd0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_seen      <= 1'b0;
        end else begin
            if (w_cnt_en) begin
                r_win_ctr <= r_win_ctr + 1'b1;
            end
            // A window end overrides a simultaneous handshake; overrun only if nobody took the old result.
            if (w_win_end) begin
                r_rate_out  <= sat_add(w_spk_cnt, bus.spike_in);
                r_out_valid <= 1'b1;
                if (r_out_valid && !bus.out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_spike) begin
                r_seen <= 1'b1;
                if (r_seen) begin
                    r_isi_out <= sat_add(w_isi_ctr, 1'b1);
                end
            end
        end
    end

    assign bus.rate_out  = r_rate_out;
    assign bus.isi_out   = r_isi_out;
    assign bus.out_valid = r_out_valid;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_rnn_spike_decoder.sv
// ============================================================================
// Module   : tb_rnn_spike_decoder
// Purpose  : Directed self-checking bench; WIN_LOG2=4 instance plus a WIN_LOG2=8 instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rnn_spike_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    rnn_spike_decoder_if bus4 ();
    rnn_spike_decoder_if bus8 ();

    rnn_spike_decoder #(.WIN_LOG2(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rnn_spike_decoder #(.WIN_LOG2(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic ena, input logic spk, input logic clr, input logic rdy);
        bus4.ena = ena; bus4.spike_in = spk; bus4.clear = clr; bus4.out_ready = rdy;
        bus8.ena = ena; bus8.spike_in = spk; bus8.clear = clr; bus8.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (bus4.rate_out !== 8'd0) begin n_fails++; $display("FAIL reset_rate: got %0d want 0", bus4.rate_out); end
        n_checks++;
        if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", bus4.out_valid); end
        n_checks++;
        if (bus4.isi_out !== 8'd0) begin n_fails++; $display("FAIL reset_isi: got %0d want 0", bus4.isi_out); end
        n_checks++;
        if (bus4.overrun !== 1'b0) begin n_fails++; $display("FAIL reset_overrun: got %b want 0", bus4.overrun); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_full_rate();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step();
        n_checks++;
        if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL full_early_valid: got %b want 0", bus4.out_valid); end
        step();
        n_checks++;
        if (bus4.rate_out !== 8'd16) begin n_fails++; $display("FAIL full_rate: got %0d want 16", bus4.rate_out); end
        n_checks++;
        if (bus4.out_valid !== 1'b1) begin n_fails++; $display("FAIL full_valid: got %b want 1", bus4.out_valid); end
        n_checks++;
        if (bus4.isi_out !== 8'd1) begin n_fails++; $display("FAIL full_isi: got %0d want 1", bus4.isi_out); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL full_valid_drop: got %b want 0", bus4.out_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) step();
        n_checks++;
        if (bus8.out_valid !== 1'b0) begin n_fails++; $display("FAIL sat_early_valid: got %b want 0", bus8.out_valid); end
        step();
        n_checks++;
        if (bus8.rate_out !== 8'd255) begin n_fails++; $display("FAIL sat_rate: got %0d want 255", bus8.rate_out); end
        n_checks++;
        if (bus8.out_valid !== 1'b1) begin n_fails++; $display("FAIL sat_valid: got %b want 1", bus8.out_valid); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, (i < 3), 1'b0, 1'b0);
            step();
        end
        n_checks++;
        if (bus4.rate_out !== 8'd3 || bus4.overrun !== 1'b0) begin
            n_fails++; $display("FAIL ovr_first: rate %0d overrun %b want 3 0", bus4.rate_out, bus4.overrun);
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, (i < 5), 1'b0, 1'b0);
            step();
        end
        n_checks++;
        if (bus4.rate_out !== 8'd5) begin n_fails++; $display("FAIL ovr_rate: got %0d want 5", bus4.rate_out); end
        n_checks++;
        if (bus4.out_valid !== 1'b1) begin n_fails++; $display("FAIL ovr_valid: got %b want 1", bus4.out_valid); end
        n_checks++;
        if (bus4.overrun !== 1'b1) begin n_fails++; $display("FAIL ovr_flag: got %b want 1", bus4.overrun); end
        n_checks++;
        if (bus4.isi_out !== 8'd1) begin n_fails++; $display("FAIL ovr_isi: got %0d want 1", bus4.isi_out); end
        // clear must win over a simultaneous enabled spike
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus4.rate_out, bus4.isi_out, bus4.out_valid, bus4.overrun} !== 18'd0) begin
            n_fails++;
            $display("FAIL clear_outputs: rate %0d isi %0d valid %b overrun %b want all 0",
                     bus4.rate_out, bus4.isi_out, bus4.out_valid, bus4.overrun);
        end
    endtask

    task automatic test_isi();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_in(1'b1, (i == 3 || i == 10), 1'b0, 1'b1);
            step();
            if (i == 3) begin
                n_checks++;
                if (bus4.isi_out !== 8'd0) begin n_fails++; $display("FAIL isi_first: got %0d want 0", bus4.isi_out); end
            end
            if (i == 9) begin
                n_checks++;
                if (bus4.isi_out !== 8'd0) begin n_fails++; $display("FAIL isi_hold: got %0d want 0", bus4.isi_out); end
            end
        end
        n_checks++;
        if (bus4.isi_out !== 8'd7) begin n_fails++; $display("FAIL isi_second: got %0d want 7", bus4.isi_out); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause();
        do_reset();
        for (int s = 1; s <= 21; s++) begin
            if (s <= 8)       set_in(1'b1, 1'b1, 1'b0, 1'b1);
            else if (s <= 13) set_in(1'b0, 1'b1, 1'b0, 1'b1);
            else              set_in(1'b1, 1'b0, 1'b0, 1'b1);
            step();
            if (s == 16 || s == 20) begin
                n_checks++;
                if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL pause_early_s%0d: valid %b want 0", s, bus4.out_valid); end
            end
        end
        n_checks++;
        if (bus4.out_valid !== 1'b1) begin n_fails++; $display("FAIL pause_valid: got %b want 1", bus4.out_valid); end
        n_checks++;
        if (bus4.rate_out !== 8'd8) begin n_fails++; $display("FAIL pause_rate: got %0d want 8", bus4.rate_out); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, (i < 4), 1'b0, (i == 15));
            step();
        end
        n_checks++;
        if (bus4.rate_out !== 8'd4) begin n_fails++; $display("FAIL b2b_rate: got %0d want 4", bus4.rate_out); end
        n_checks++;
        if (bus4.out_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_valid: got %b want 1", bus4.out_valid); end
        n_checks++;
        if (bus4.overrun !== 1'b0) begin n_fails++; $display("FAIL b2b_overrun: got %b want 0", bus4.overrun); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_drop: got %b want 0", bus4.out_valid); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, (i < 2), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, (i < 4), 1'b0, 1'b0);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus4.rate_out, bus4.isi_out, bus4.out_valid, bus4.overrun} !== 18'd0) begin
            n_fails++;
            $display("FAIL rst_async: rate %0d isi %0d valid %b overrun %b want all 0",
                     bus4.rate_out, bus4.isi_out, bus4.out_valid, bus4.overrun);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, (i < 6), 1'b0, 1'b1);
            step();
            n_checks++;
            if (bus4.out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_early_valid_%0d: got %b want 0", i, bus4.out_valid); end
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus4.out_valid !== 1'b1) begin n_fails++; $display("FAIL rst_post_valid: got %b want 1", bus4.out_valid); end
        n_checks++;
        if (bus4.rate_out !== 8'd6) begin n_fails++; $display("FAIL rst_post_rate: got %0d want 6", bus4.rate_out); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_full_rate();
        test_saturate();
        test_overrun();
        test_isi();
        test_pause();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rnn_spike_decoder.md
RNN_SPIKE_DECODER -- requirements
Module: rnn_spike_decoder

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 8, meaning the window length is 2^WIN_LOG2 enabled cycles (legal range 2..12).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ena, input, 1 bit: count enable; low pauses all counters.
REQ-005 The block SHALL have port spike_in, input, 1 bit: the neuron spike flag, sampled on each clk edge.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous soft reset.
REQ-007 The block SHALL have port out_ready, input, 1 bit: consumer accepts rate_out.
REQ-008 The block SHALL have port rate_out, output, 8 bits: spike count of the last completed window.
REQ-009 The block SHALL have port out_valid, output, 1 bit: rate_out holds an unconsumed result.
REQ-010 The block SHALL have port isi_out, output, 8 bits: last inter-spike interval in enabled cycles.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set when a result was overwritten unconsumed.

Function
REQ-012 The FSM SHALL have states IDLE and COUNT; IDLE -> COUNT on the first cycle with ena=1, and that cycle SHALL be window cycle 0.
REQ-013 In COUNT, ena=0 SHALL freeze win_ctr, spk_cnt and isi_ctr, with the FSM remaining in COUNT.
REQ-014 On each enabled cycle, win_ctr SHALL increment modulo 2^WIN_LOG2, and spike_in=1 SHALL increment spk_cnt, saturating at 255.
REQ-015 On the enabled cycle with win_ctr = 2^WIN_LOG2-1, the edge SHALL load rate_out = sat255(spk_cnt + spike_in), set out_valid=1 and zero spk_cnt; the next window SHALL start on the following enabled cycle with no gap.
REQ-016 Handshake: out_valid SHALL fall on the edge after a cycle with out_valid=1 and out_ready=1; rate_out SHALL remain stable while out_valid=1, except on overwrite.
REQ-017 Window end with out_valid=1 and out_ready=0 SHALL overwrite rate_out, keep out_valid=1 and set overrun=1.
REQ-018 Window end in the same cycle as a handshake SHALL load the new value with out_valid=1 and SHALL NOT set overrun.
REQ-019 isi_ctr SHALL increment, saturating at 255, on each enabled cycle with spike_in=0.
REQ-020 On an enabled spike, isi_ctr SHALL reset to 0, and isi_out SHALL load sat255(isi_ctr+1) only if a prior spike has been seen since reset/clear; the first spike SHALL only set the seen bit.
REQ-021 clear=1 SHALL, at the next edge, zero all counters, rate_out, isi_out, out_valid, overrun and the seen bit, and enter IDLE; clear SHALL take priority over every other event in that cycle.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, rate_out=0, isi_out=0, out_valid=0, overrun=0, and all counters and the seen bit to 0, independent of clk.
REQ-023 Assertion of rst mid-window SHALL discard the partial window, and no out_valid SHALL be produced for it.
REQ-024 After rst deasserts, the block SHALL count from window cycle 0 at the first enabled cycle.

Structure
REQ-025 The FSM state encoding, the saturation value 255 and the default WIN_LOG2 SHALL be defined in shared package rnn_pkg.
REQ-026 A single sub-module, rnn_sat_counter (8-bit, enable, sync clear, saturate at 255), SHALL be instantiated for spk_cnt and for isi_ctr; all other logic SHALL be flat.
REQ-027 All outputs SHALL be driven directly from registers.

Verification (WIN_LOG2=4 unless stated)
REQ-028 With ena=1, spike_in=1 for 16 cycles and out_ready=1, the bench SHALL check rate_out=16 and out_valid high for 1 cycle after the 16th edge, and isi_out=1.
REQ-029 With WIN_LOG2=8 and spike_in=1 constantly, the bench SHALL check rate_out=255 with no wrap.
REQ-030 With out_ready=0 across two windows of 3 then 5 spikes, the bench SHALL check rate_out=5, out_valid=1 and overrun=1, and then that a clear pulse zeroes all outputs.
REQ-031 With spikes on enabled cycles 3 and 10 only, the bench SHALL check isi_out=0 after cycle 3 and isi_out=7 after cycle 10.
REQ-032 With ena=0 for 5 cycles mid-window, the bench SHALL check that window end is delayed exactly 5 cycles and the count is unchanged.
REQ-033 With rst pulsed at window cycle 9 with 4 spikes counted, the bench SHALL check that outputs are 0 before the next edge and that the first out_valid after release reports only post-reset spikes.
